spi2adc: RTL and testbench

- SPI initiator that reads one 10-bit conversion from an MCP3002-class ADC on each `start` pulse.
- Mirror of `spi2dac`: the DAC path writes samples out, this block reads samples in, using the same `tick`-driven sample-rate scheme.
- Sits between the sample-rate tick generator and downstream processing (`pwm`/`spi2dac` loopback, filters).
- Delivers `data_out` plus a one-cycle `data_valid` strobe.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_half_tick.sv | 33 +++
 rtl/spi2adc.sv | 132 +++++++++++++
 tb/tb_spi2adc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI framing constants, FSM encoding and command-bit helper.
// Used by both the ADC reader and the DAC writer.
package spi_pkg;

   localparam int FRAME_BITS      = 16;
   localparam int CMD_BITS        = 4;
   localparam int DATA_FIRST_EDGE = 7;
   localparam int ADC_W           = 10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_GAP
   } spi_state_e;

   // MCP3002 command, MSB first: start, SGL/DIFF, ODD/SIGN, MSBF; zero afterwards.
   function automatic logic cmd_bit(input logic [4:0] edge_no, input logic sgl, input logic odd);
      logic b;
      case (edge_no)
         5'd1:    b = 1'b1;
         5'd2:    b = sgl;
         5'd3:    b = odd;
         5'd4:    b = 1'b1;
         default: b = 1'b0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_half_tick.sv
// CLK_DIV prescaler: one-cycle pulse at the end of every SCK half-period.
// clr holds the count at zero so each frame starts on a fresh half-period.
module spi_half_tick #(
   parameter int CLK_DIV = 25
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   logic [7:0] cnt_q, cnt_d;
   logic       term;

   assign term   = (cnt_q == 8'(CLK_DIV - 1));
   assign tick_o = en_i && !clr_i && term;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = term ? 8'd0 : cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/spi2adc.sv
// SPI initiator reading one 10-bit MCP3002 conversion per accepted start pulse.
// SCK, CS and SDI come straight from flops; SDO is captured on SCK rising edges.
module spi2adc
   import spi_pkg::*;
#(
   parameter int   CLK_DIV = 25,
   parameter logic SGL     = 1'b1
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             channel,
   input  logic             ADC_SDO,
   output logic             ADC_CS,
   output logic             ADC_SCK,
   output logic             ADC_SDI,
   output logic [ADC_W-1:0] data_out,
   output logic             data_valid,
   output logic             busy
);

   localparam logic [4:0] H_LAST = 5'(2 * FRAME_BITS - 1);

   spi_state_e       state_q, state_d;
   logic [4:0]       h_q, h_d;
   logic             ch_q, ch_d;
   logic [ADC_W-1:0] sh_q, sh_d;
   logic             sck_q, sck_d;
   logic             cs_q, cs_d;
   logic             sdi_q, sdi_d;
   logic [ADC_W-1:0] dout_q, dout_d;
   logic             dv_q, dv_d;
   logic             tick;
   logic [4:0]       edge_nxt;

   spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_i  (sysclk),
      .rst_ni (rst_n),
      .en_i   (state_q != S_IDLE),
      .clr_i  (state_q == S_IDLE),
      .tick_o (tick)
   );

   // Number of the next rising edge, valid in both the high and low half of period h/2.
   assign edge_nxt = {1'b0, h_q[4:1]} + 5'd2;

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      ch_d    = ch_q;
      sh_d    = sh_q;
      sck_d   = sck_q;
      cs_d    = cs_q;
      sdi_d   = sdi_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETUP;
               ch_d    = channel;
               cs_d    = 1'b0;
               sdi_d   = cmd_bit(5'd1, SGL, channel);
               h_d     = '0;
               sh_d    = '0;
            end
         end
         S_SETUP: begin
            if (tick) begin
               state_d = S_SHIFT;
               sck_d   = 1'b1;
            end
         end
         S_SHIFT: begin
            if (tick) begin
               if (h_q == H_LAST) begin
                  state_d = S_GAP;
                  cs_d    = 1'b1;
                  sdi_d   = 1'b0;
                  dout_d  = sh_q;
                  dv_d    = 1'b1;
               end else begin
                  h_d   = h_q + 5'd1;
                  sck_d = ~sck_q;
                  // Falling edge updates MOSI; rising edge captures MISO once data bits start.
                  if (sck_q) begin
                     sdi_d = cmd_bit(edge_nxt, SGL, ch_q);
                  end else if (edge_nxt >= 5'(DATA_FIRST_EDGE)) begin
                     sh_d = {sh_q[ADC_W-2:0], ADC_SDO};
                  end
               end
            end
         end
         S_GAP: begin
            if (tick) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         h_q     <= '0;
         ch_q    <= 1'b0;
         sh_q    <= '0;
         sck_q   <= 1'b0;
         cs_q    <= 1'b1;
         sdi_q   <= 1'b0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         ch_q    <= ch_d;
         sh_q    <= sh_d;
         sck_q   <= sck_d;
         cs_q    <= cs_d;
         sdi_q   <= sdi_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
      end
   end

   assign ADC_CS     = cs_q;
   assign ADC_SCK    = sck_q;
   assign ADC_SDI    = sdi_q;
   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi2adc.sv
// Bench for spi2adc with CLK_DIV = 4 and an MCP3002-like SDO model that decodes the command.
module tb_spi2adc;

   localparam int D     = 4;
   localparam int FRAME = 34 * D + 1;

   logic       sysclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       channel = 1'b0;
   logic       ADC_SDO = 1'b0;
   logic       ADC_CS;
   logic       ADC_SCK;
   logic       ADC_SDI;
   logic [9:0] data_out;
   logic       data_valid;
   logic       busy;

   int checks = 0;
   int failures = 0;

   spi2adc #(.CLK_DIV(D), .SGL(1'b1)) dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .start      (start),
      .channel    (channel),
      .ADC_SDO    (ADC_SDO),
      .ADC_CS     (ADC_CS),
      .ADC_SCK    (ADC_SCK),
      .ADC_SDI    (ADC_SDI),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy)
   );

   always #10 sysclk = ~sysclk;

   // ADC model: 0 = conversion result per decoded channel, 1 = SDO stuck 1, 2 = SDO stuck 0.
   int         sdo_mode = 0;
   int         edge_k = 0;
   logic [3:0] cmd_seen = '0;
   logic       late_sdi = 1'b0;
   logic       prev_cs = 1'b1;
   logic       prev_sck = 1'b0;

   function automatic logic [9:0] adc_code(input logic ch);
      return ch ? 10'h15A : 10'h2A5;
   endfunction

   function automatic logic sdo_for(input int k);
      logic [9:0] s;
      if (sdo_mode == 1) return 1'b1;
      if (sdo_mode == 2) return 1'b0;
      if (k >= 7 && k <= 16) begin
         s = adc_code(cmd_seen[1]) << (k - 7);
         return s[9];
      end
      return 1'($urandom_range(0, 1));
   endfunction

   always @(negedge sysclk) begin
      if (prev_cs && !ADC_CS) begin
         edge_k   = 0;
         cmd_seen = '0;
         late_sdi = 1'b0;
         ADC_SDO  = sdo_for(1);
      end else if (!ADC_CS) begin
         if (!prev_sck && ADC_SCK) begin
            edge_k = edge_k + 1;
            if (edge_k <= 4) cmd_seen = {cmd_seen[2:0], ADC_SDI};
            else             late_sdi = late_sdi | ADC_SDI;
         end else if (prev_sck && !ADC_SCK) begin
            ADC_SDO = sdo_for(edge_k + 1);
         end
      end
      prev_cs  = ADC_CS;
      prev_sck = ADC_SCK;
   end

   // One full frame starting at the current negedge; ign1/ign2 are cycles of extra start pulses.
   task automatic run_frame(input logic ch, input int ign1, input int ign2, input logic toggle_ch,
                            input logic [9:0] exp_val, input string tag);
      int         cs_err = 0, sck_err = 0, busy_err = 0, dv_cnt = 0, dv_at = -1;
      logic [9:0] dout_at = '0;
      logic       exp_cs, exp_sck, exp_busy;
      channel = ch;
      start   = 1'b1;
      for (int c = 1; c <= FRAME; c++) begin
         @(negedge sysclk);
         start = (c == ign1 || c == ign2);
         if (toggle_ch) channel = 1'($urandom_range(0, 1));
         exp_cs   = !(c <= 33 * D);
         exp_sck  = ((c - 1) >= D) && ((c - 1) < 33 * D) && ((((c - 1) / D) % 2) == 1);
         exp_busy = (c <= 34 * D);
         if (ADC_CS !== exp_cs)   cs_err++;
         if (ADC_SCK !== exp_sck) sck_err++;
         if (busy !== exp_busy)   busy_err++;
         if (data_valid === 1'b1) begin
            dv_cnt++;
            dv_at   = c;
            dout_at = data_out;
         end
      end
      start = 1'b0;
      checks++;
      if (cs_err !== 0) begin failures++; $display("FAIL %s cs_timing bad_cycles=%0d want 0", tag, cs_err); end
      checks++;
      if (sck_err !== 0) begin failures++; $display("FAIL %s sck_timing bad_cycles=%0d want 0", tag, sck_err); end
      checks++;
      if (busy_err !== 0) begin failures++; $display("FAIL %s busy_timing bad_cycles=%0d want 0", tag, busy_err); end
      checks++;
      if (dv_cnt !== 1) begin failures++; $display("FAIL %s valid_count got=%0d want 1", tag, dv_cnt); end
      checks++;
      if (dv_at !== 33 * D + 1) begin failures++; $display("FAIL %s valid_cycle got=T+%0d want T+%0d", tag, dv_at, 33 * D + 1); end
      checks++;
      if (dout_at !== exp_val) begin failures++; $display("FAIL %s data_out got=%h want %h", tag, dout_at, exp_val); end
      checks++;
      if (data_out !== exp_val) begin failures++; $display("FAIL %s data_hold got=%h want %h", tag, data_out, exp_val); end
      checks++;
      if (cmd_seen !== {1'b1, 1'b1, ch, 1'b1}) begin failures++; $display("FAIL %s command got=%b want %b", tag, cmd_seen, {1'b1, 1'b1, ch, 1'b1}); end
      checks++;
      if (late_sdi !== 1'b0 || edge_k !== 16) begin failures++; $display("FAIL %s tail late_sdi=%b edges=%0d want 0/16", tag, late_sdi, edge_k); end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic test_reset();
      int bad_cs = 0, bad_sck = 0, bad_sdi = 0, bad_dout = 0, bad_busy = 0, bad_dv = 0;
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge sysclk);
         if (ADC_CS !== 1'b1)    bad_cs++;
         if (ADC_SCK !== 1'b0)   bad_sck++;
         if (ADC_SDI !== 1'b0)   bad_sdi++;
         if (data_out !== 10'h0) bad_dout++;
         if (busy !== 1'b0)      bad_busy++;
         if (data_valid !== 1'b0) bad_dv++;
      end
      checks++; if (bad_cs !== 0)   begin failures++; $display("FAIL reset cs bad=%0d want 0", bad_cs); end
      checks++; if (bad_sck !== 0)  begin failures++; $display("FAIL reset sck bad=%0d want 0", bad_sck); end
      checks++; if (bad_sdi !== 0)  begin failures++; $display("FAIL reset sdi bad=%0d want 0", bad_sdi); end
      checks++; if (bad_dout !== 0) begin failures++; $display("FAIL reset data_out bad=%0d want 0", bad_dout); end
      checks++; if (bad_busy !== 0) begin failures++; $display("FAIL reset busy bad=%0d want 0", bad_busy); end
      checks++; if (bad_dv !== 0)   begin failures++; $display("FAIL reset data_valid bad=%0d want 0", bad_dv); end
   endtask

   task automatic test_channels();
      idle($urandom_range(1, 5));
      run_frame(1'b0, 0, 0, 1'b0, adc_code(1'b0), "ch0");
      idle($urandom_range(1, 5));
      run_frame(1'b1, 0, 0, 1'b0, adc_code(1'b1), "ch1");
   endtask

   task automatic test_ignore_and_back_to_back();
      logic ch;
      idle(2);
      run_frame(1'b0, 10, 100, 1'b0, adc_code(1'b0), "ignore");
      ch = 1'($urandom_range(0, 1));
      run_frame(ch, $urandom_range(1, 34 * D - 1), $urandom_range(1, 34 * D - 1), 1'b1,
                adc_code(ch), "back_to_back");
   endtask

   task automatic test_reset_mid();
      int   waited = 0;
      logic ch;
      idle(3);
      channel = 1'b1;
      start   = 1'b1;
      @(negedge sysclk);
      start = 1'b0;
      while (edge_k < 9 && waited < 200) begin
         @(negedge sysclk);
         waited++;
      end
      checks++;
      if (edge_k < 9) begin failures++; $display("FAIL midreset wait_edge9 edges=%0d want 9", edge_k); end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({ADC_CS, ADC_SCK, ADC_SDI, busy, data_valid} !== 5'b10000 || data_out !== 10'h0) begin
         failures++;
         $display("FAIL midreset outputs cs/sck/sdi/busy/dv=%b data=%h want 10000/000",
                  {ADC_CS, ADC_SCK, ADC_SDI, busy, data_valid}, data_out);
      end
      idle(3);
      rst_n = 1'b1;
      idle(2);
      ch = 1'($urandom_range(0, 1));
      run_frame(ch, 0, 0, 1'b0, adc_code(ch), "after_reset");
   endtask

   task automatic test_constant_sdo();
      idle(2);
      sdo_mode = 1;
      run_frame(1'($urandom_range(0, 1)), 0, 0, 1'b0, 10'h3FF, "sdo_one");
      sdo_mode = 2;
      run_frame(1'($urandom_range(0, 1)), 0, 0, 1'b0, 10'h000, "sdo_zero");
      sdo_mode = 0;
   endtask

   task automatic test_random();
      logic ch;
      for (int i = 0; i < 6; i++) begin
         idle($urandom_range(0, 3));
         ch = 1'($urandom_range(0, 1));
         run_frame(ch, $urandom_range(1, 34 * D - 1), 0, 1'($urandom_range(0, 1)),
                   adc_code(ch), "random");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_channels();
      test_ignore_and_back_to_back();
      test_reset_mid();
      test_constant_sdo();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
